// File: rtl/segment_display_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : segment_display_arbiter_if
// Description : Request/grant bundle between the three value producers and
//               the two-digit display arbiter.
//               slave  - arbiter side (samples requests and values, drives
//                        grant and busy)
//               master - requester side (drives requests and values,
//                        observes grant and busy)
//   i_Req     [2:0] level request, bit n belongs to requester n
//   i_Value_0 [6:0] requester 0 value, 0-99
//   i_Value_1 [6:0] requester 1 value, 0-99
//   i_Value_2 [6:0] requester 2 value, 0-99
//   o_Grant   [2:0] one-hot grant, all zero when idle
//   o_Busy          OR of o_Grant
// Revision    : 1.0 - initial release
// ============================================================================
interface segment_display_arbiter_if;
    logic [2:0] i_Req;
    logic [6:0] i_Value_0;
    logic [6:0] i_Value_1;
    logic [6:0] i_Value_2;
    logic [2:0] o_Grant;
    logic       o_Busy;

    modport slave (
        input  i_Req,
        input  i_Value_0,
        input  i_Value_1,
        input  i_Value_2,
        output o_Grant,
        output o_Busy
    );

    modport master (
        output i_Req,
        output i_Value_0,
        output i_Value_1,
        output i_Value_2,
        input  o_Grant,
        input  o_Busy
    );
endinterface
`default_nettype wire

// File: rtl/segment_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : segment_display_arbiter
// Description : Round-robin arbiter sharing the board's two 7-segment digits
//               among three requesters. A new grant is protected from
//               preemption for HOLD_CYCLES cycles; after that any other
//               requester takes over in round-robin order. The granted value
//               is split into tens/units and drives both digits active-low.
//   i_Clk              system clock (25 MHz)
//   i_Rst_L            asynchronous active-low reset
//   bus (slave)        requests, values, grant, busy
//   o_Segment1_A..G    tens digit (left), active-low
//   o_Segment2_A..G    units digit (right), active-low
// Revision    : 1.0 - initial release
// ============================================================================
module segment_display_arbiter #(
    parameter int HOLD_CYCLES = 12_500_000
) (
    input  wire                         i_Clk,
    input  wire                         i_Rst_L,
    segment_display_arbiter_if.slave    bus,
    output logic                        o_Segment1_A,
    output logic                        o_Segment1_B,
    output logic                        o_Segment1_C,
    output logic                        o_Segment1_D,
    output logic                        o_Segment1_E,
    output logic                        o_Segment1_F,
    output logic                        o_Segment1_G,
    output logic                        o_Segment2_A,
    output logic                        o_Segment2_B,
    output logic                        o_Segment2_C,
    output logic                        o_Segment2_D,
    output logic                        o_Segment2_E,
    output logic                        o_Segment2_F,
    output logic                        o_Segment2_G
);

    localparam int                 c_CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    // {G,F,E,D,C,B,A}, active-low
    localparam logic [6:0]         c_SEG_BLANK = 7'b111_1111;
    localparam logic [6:0]         c_SEG_DASH  = 7'b011_1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_OPEN = 2'd2
    } t_state;

    t_state               r_State;
    logic [2:0]           r_Grant;
    logic                 r_Busy;
    logic [1:0]           r_Last;
    logic [c_CNT_W-1:0]   r_Count;
    logic [6:0]           r_Value;
    logic                 r_Value_Valid;
    logic [6:0]           r_Seg1;
    logic [6:0]           r_Seg2;

    logic [1:0]           w_Order0;
    logic [1:0]           w_Order1;
    logic [1:0]           w_Order2;
    logic                 w_Pick_Valid;
    logic [1:0]           w_Pick_Idx;
    logic                 w_Holder_Req;
    logic                 w_Others_Req;
    logic [6:0]           w_Granted_Value;
    logic [3:0]           w_Tens;
    logic [3:0]           w_Units;
    logic [6:0]           w_Disp1;
    logic [6:0]           w_Disp2;

    function automatic logic [1:0] f_next(input logic [1:0] idx);
        f_next = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [2:0] f_onehot(input logic [1:0] idx);
        f_onehot = 3'(3'b001 << idx);
    endfunction

    // Active-high {G,F,E,D,C,B,A} pattern for a decimal digit.
    function automatic logic [6:0] f_digit(input logic [3:0] d);
        case (d)
            4'd0:    f_digit = 7'b011_1111;
            4'd1:    f_digit = 7'b000_0110;
            4'd2:    f_digit = 7'b101_1011;
            4'd3:    f_digit = 7'b100_1111;
            4'd4:    f_digit = 7'b110_0110;
            4'd5:    f_digit = 7'b110_1101;
            4'd6:    f_digit = 7'b111_1101;
            4'd7:    f_digit = 7'b000_0111;
            4'd8:    f_digit = 7'b111_1111;
            4'd9:    f_digit = 7'b110_1111;
            default: f_digit = 7'b000_0000;
        endcase
    endfunction

    // Search order starts one past the last holder, so the current holder is
    // always the last candidate: picking the first active requester in this
    // order yields a non-holder whenever one is requesting.
    always_comb begin
        w_Order0     = f_next(r_Last);
        w_Order1     = f_next(w_Order0);
        w_Order2     = f_next(w_Order1);
        w_Pick_Valid = |bus.i_Req;
        w_Pick_Idx   = w_Order2;
        if (bus.i_Req[w_Order1]) w_Pick_Idx = w_Order1;
        if (bus.i_Req[w_Order0]) w_Pick_Idx = w_Order0;
    end

    assign w_Holder_Req = |(bus.i_Req & r_Grant);
    assign w_Others_Req = |(bus.i_Req & ~r_Grant);

    always_comb begin
        case (r_Grant)
            3'b001:  w_Granted_Value = bus.i_Value_0;
            3'b010:  w_Granted_Value = bus.i_Value_1;
            3'b100:  w_Granted_Value = bus.i_Value_2;
            default: w_Granted_Value = r_Value;
        endcase
    end

    assign w_Tens  = 4'(r_Value / 7'd10);
    assign w_Units = 4'(r_Value % 7'd10);

    always_comb begin
        if (r_Value > 7'd99) begin
            w_Disp1 = c_SEG_DASH;
            w_Disp2 = c_SEG_DASH;
        end else begin
            w_Disp1 = ~f_digit(w_Tens);
            w_Disp2 = ~f_digit(w_Units);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State       <= S_IDLE;
            r_Grant       <= 3'b000;
            r_Busy        <= 1'b0;
            r_Last        <= 2'd2;
            r_Count       <= '0;
            r_Value       <= 7'd0;
            r_Value_Valid <= 1'b0;
            r_Seg1        <= c_SEG_BLANK;
            r_Seg2        <= c_SEG_BLANK;
        end else begin
            // ---------------- arbitration ----------------
            case (r_State)
                S_IDLE: begin
                    if (w_Pick_Valid) begin
                        r_State <= S_HOLD;
                        r_Grant <= f_onehot(w_Pick_Idx);
                        r_Busy  <= 1'b1;
                        r_Last  <= w_Pick_Idx;
                        r_Count <= '0;
                    end
                end

                S_HOLD, S_OPEN: begin
                    if (!w_Holder_Req) begin
                        // Release takes priority over hold expiry.
                        if (w_Pick_Valid) begin
                            r_State <= S_HOLD;
                            r_Grant <= f_onehot(w_Pick_Idx);
                            r_Busy  <= 1'b1;
                            r_Last  <= w_Pick_Idx;
                            r_Count <= '0;
                        end else begin
                            r_State <= S_IDLE;
                            r_Grant <= 3'b000;
                            r_Busy  <= 1'b0;
                        end
                    end else if (r_State == S_OPEN || r_Count == c_HOLD_LAST) begin
                        // Hold has run its full length: preemptible now.
                        if (w_Others_Req) begin
                            r_State <= S_HOLD;
                            r_Grant <= f_onehot(w_Pick_Idx);
                            r_Busy  <= 1'b1;
                            r_Last  <= w_Pick_Idx;
                            r_Count <= '0;
                        end else begin
                            r_State <= S_OPEN;
                        end
                    end else begin
                        r_Count <= r_Count + 1'b1;
                    end
                end

                default: begin
                    r_State <= S_IDLE;
                    r_Grant <= 3'b000;
                    r_Busy  <= 1'b0;
                end
            endcase

            // ---------------- datapath ----------------
            // r_Value_Valid lags the grant by one cycle so the first displayed
            // value after a fresh grant is the newly loaded one, not a stale
            // value left from an earlier holder.
            r_Value       <= w_Granted_Value;
            r_Value_Valid <= |r_Grant;
            if (r_Value_Valid && (|r_Grant)) begin
                r_Seg1 <= w_Disp1;
                r_Seg2 <= w_Disp2;
            end else begin
                r_Seg1 <= c_SEG_BLANK;
                r_Seg2 <= c_SEG_BLANK;
            end
        end
    end

    assign bus.o_Grant = r_Grant;
    assign bus.o_Busy  = r_Busy;

    assign o_Segment1_A = r_Seg1[0];
    assign o_Segment1_B = r_Seg1[1];
    assign o_Segment1_C = r_Seg1[2];
    assign o_Segment1_D = r_Seg1[3];
    assign o_Segment1_E = r_Seg1[4];
    assign o_Segment1_F = r_Seg1[5];
    assign o_Segment1_G = r_Seg1[6];
    assign o_Segment2_A = r_Seg2[0];
    assign o_Segment2_B = r_Seg2[1];
    assign o_Segment2_C = r_Seg2[2];
    assign o_Segment2_D = r_Seg2[3];
    assign o_Segment2_E = r_Seg2[4];
    assign o_Segment2_F = r_Seg2[5];
    assign o_Segment2_G = r_Seg2[6];

endmodule
`default_nettype wire

// File: tb/tb_segment_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_segment_display_arbiter
// Description : Directed self-checking bench for segment_display_arbiter with
//               HOLD_CYCLES = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segment_display_arbiter;

    logic r_Clk = 1'b0;
    logic r_Rst_L = 1'b0;
    int   r_Compared = 0;
    int   r_Mismatched = 0;

    logic w_S1A, w_S1B, w_S1C, w_S1D, w_S1E, w_S1F, w_S1G;
    logic w_S2A, w_S2B, w_S2C, w_S2D, w_S2E, w_S2F, w_S2G;
    logic [13:0] w_Seg;

    segment_display_arbiter_if bus_if ();

    segment_display_arbiter #(.HOLD_CYCLES(4)) dut (
        .i_Clk        (r_Clk),
        .i_Rst_L      (r_Rst_L),
        .bus          (bus_if),
        .o_Segment1_A (w_S1A),
        .o_Segment1_B (w_S1B),
        .o_Segment1_C (w_S1C),
        .o_Segment1_D (w_S1D),
        .o_Segment1_E (w_S1E),
        .o_Segment1_F (w_S1F),
        .o_Segment1_G (w_S1G),
        .o_Segment2_A (w_S2A),
        .o_Segment2_B (w_S2B),
        .o_Segment2_C (w_S2C),
        .o_Segment2_D (w_S2D),
        .o_Segment2_E (w_S2E),
        .o_Segment2_F (w_S2F),
        .o_Segment2_G (w_S2G)
    );

    assign w_Seg = {w_S1G, w_S1F, w_S1E, w_S1D, w_S1C, w_S1B, w_S1A,
                    w_S2G, w_S2F, w_S2E, w_S2D, w_S2C, w_S2B, w_S2A};

    always #5 r_Clk = ~r_Clk;

    // Expected active-low display words {tens G..A, units G..A}.
    localparam logic [13:0] c_BLANK = 14'b1111111_1111111;
    localparam logic [13:0] c_DASH  = 14'b0111111_0111111;
    localparam logic [13:0] c_42    = 14'b0011001_0100100;
    localparam logic [13:0] c_00    = 14'b1000000_1000000;
    localparam logic [13:0] c_99    = 14'b0010000_0010000;
    localparam logic [13:0] c_09    = 14'b1000000_0010000;
    localparam logic [13:0] c_10    = 14'b1111001_1000000;

    task automatic tick();
        @(posedge r_Clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [2:0] exp);
        r_Compared++;
        assert (bus_if.o_Grant === exp)
        else begin
            r_Mismatched++;
            $error("FAIL %s: o_Grant observed %b expected %b", tag, bus_if.o_Grant, exp);
        end
    endtask

    task automatic chk_busy(input string tag, input logic exp);
        r_Compared++;
        assert (bus_if.o_Busy === exp)
        else begin
            r_Mismatched++;
            $error("FAIL %s: o_Busy observed %b expected %b", tag, bus_if.o_Busy, exp);
        end
    endtask

    task automatic chk_seg(input string tag, input logic [13:0] exp);
        r_Compared++;
        assert (w_Seg === exp)
        else begin
            r_Mismatched++;
            $error("FAIL %s: segments observed %b expected %b", tag, w_Seg, exp);
        end
    endtask

    initial begin
        bus_if.i_Req     = 3'b000;
        bus_if.i_Value_0 = 7'd0;
        bus_if.i_Value_1 = 7'd11;
        bus_if.i_Value_2 = 7'd22;
        repeat (3) tick();
        chk_grant("reset_grant", 3'b000);
        chk_busy("reset_busy", 1'b0);
        chk_seg("reset_seg", c_BLANK);
        r_Rst_L = 1'b1;
        tick();

        // Single requester showing 42
        bus_if.i_Req     = 3'b001;
        bus_if.i_Value_0 = 7'd42;
        tick();
        chk_grant("single_grant", 3'b001);
        chk_busy("single_busy", 1'b1);
        chk_seg("single_seg_lat0", c_BLANK);
        tick();
        chk_seg("single_seg_lat1", c_BLANK);
        tick();
        chk_seg("single_seg_42", c_42);
        repeat (6) tick();
        chk_grant("single_open_grant", 3'b001);
        chk_seg("single_open_seg", c_42);

        // Asynchronous reset mid-grant
        #2 r_Rst_L = 1'b0;
        #1;
        chk_grant("async_rst_grant", 3'b000);
        chk_busy("async_rst_busy", 1'b0);
        chk_seg("async_rst_seg", c_BLANK);
        tick();
        r_Rst_L = 1'b1;
        tick();
        chk_grant("post_rst_grant", 3'b001);

        // Release to idle; display blanks one edge later
        bus_if.i_Req = 3'b000;
        tick();
        chk_grant("release_grant", 3'b000);
        chk_busy("release_busy", 1'b0);
        tick();
        chk_seg("release_seg", c_BLANK);

        // Round-robin with hold: last holder was 0, so 1 goes first
        bus_if.i_Req = 3'b111;
        tick();
        repeat (4) begin chk_grant("rr_g1", 3'b010); tick(); end
        repeat (4) begin chk_grant("rr_g2", 3'b100); tick(); end
        repeat (4) begin chk_grant("rr_g0", 3'b001); tick(); end
        chk_grant("rr_g1_again", 3'b010);

        // Early release: holder 1 drops after 2 cycles while 2 requests
        bus_if.i_Req = 3'b110;
        tick();
        tick();
        chk_grant("early_still_1", 3'b010);
        bus_if.i_Req = 3'b100;
        tick();
        chk_grant("early_to_2", 3'b100);
        chk_busy("early_busy", 1'b1);
        bus_if.i_Req = 3'b000;
        tick();
        chk_grant("all_low_idle", 3'b000);
        chk_busy("all_low_busy", 1'b0);

        // Boundaries (last holder 2, so requester 0 is first)
        bus_if.i_Req     = 3'b001;
        bus_if.i_Value_0 = 7'd0;
        tick();
        chk_grant("bnd_grant", 3'b001);
        tick();
        tick();
        chk_seg("bnd_00", c_00);
        bus_if.i_Value_0 = 7'd99;
        tick();
        chk_seg("bnd_99_lat", c_00);
        tick();
        chk_seg("bnd_99", c_99);
        bus_if.i_Value_0 = 7'd100;
        tick();
        tick();
        chk_seg("bnd_100", c_DASH);
        bus_if.i_Value_0 = 7'd127;
        tick();
        tick();
        chk_seg("bnd_127", c_DASH);
        bus_if.i_Value_0 = 7'd9;
        tick();
        tick();
        chk_seg("bnd_09", c_09);
        bus_if.i_Value_0 = 7'd10;
        tick();
        chk_seg("bnd_10_lat", c_09);
        tick();
        chk_seg("bnd_10", c_10);

        // Simultaneous drop and expiry, then check hold restarts at 0
        bus_if.i_Req = 3'b000;
        tick();
        chk_grant("sim_idle", 3'b000);
        bus_if.i_Req = 3'b001;
        tick();
        chk_grant("sim_grant0", 3'b001);
        tick();
        tick();
        tick();
        bus_if.i_Req = 3'b010;
        tick();
        chk_grant("sim_switch", 3'b010);
        bus_if.i_Req = 3'b011;
        tick();
        chk_grant("sim_hold1", 3'b010);
        tick();
        chk_grant("sim_hold2", 3'b010);
        tick();
        chk_grant("sim_hold3", 3'b010);
        tick();
        chk_grant("sim_preempt", 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", r_Compared, r_Mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/segment_display_arbiter.md
# segment_display_arbiter

Shares the board's two 7-segment digits among three requesters: a free-running counter, a button tally and a debug value. Each requester presents a 0–99 value and a level request. The block grants the display round-robin with a guaranteed minimum hold time and drives both digits, active-low, from the granted value. It sits between the value-producing blocks and the `o_Segment1_*` / `o_Segment2_*` top-level pins and replaces any direct digit-driving logic.

## Interface
- `HOLD_CYCLES`, default 12_500_000: minimum number of cycles a grant is protected from preemption (0.5 s at 25 MHz). Legal range ≥ 1; sim uses 4.
- `i_Clk`  in  1  system clock, 25 MHz.
- `i_Rst_L`  in  1  asynchronous, active-low reset. Asserts asynchronously; deasserts synchronously via an upstream synchronizer.
- `i_Req`  in  3  level request per requester; bit n belongs to requester n.
- `i_Value_0`, `i_Value_1`, `i_Value_2`  in  7 each  requester values; legal range 0–99.
- `o_Grant`  out  3  one-hot grant, or all zero when idle.
- `o_Busy`  out  1  OR of `o_Grant`.
- `o_Segment1_A`..`o_Segment1_G`  out  1 each  tens digit (left), active-low.
- `o_Segment2_A`..`o_Segment2_G`  out  1 each  units digit (right), active-low.

## Operation
**States**
- `IDLE`: no grant.
- `HOLD`: granted, hold counter running.
- `OPEN`: granted, hold expired, preemptible.

**Arbitration**
- Round-robin pointer `r_Last` (2 bits) holds the last granted index.
- The search order starts at `r_Last+1` mod 3.
- On a new grant, `r_Last` ← the granted index and the hold counter ← 0.

**Transitions**
- `IDLE` → `HOLD` when any `i_Req` bit is high; the grant goes to the first requester in search order.
- In `HOLD`, the counter increments each cycle.
  - When the counter reaches `HOLD_CYCLES-1`, the next state is `OPEN`.
- Holder drops its request (in `HOLD` or `OPEN`):
  - If another requester is active, the grant moves directly to it and the state enters `HOLD`; there is no idle gap.
  - Otherwise the state goes to `IDLE`.
- In `OPEN`, if another requester is active, the grant moves to it in search order and the state enters `HOLD`.
- In `OPEN`, if only the holder requests, the state stays in `OPEN`.
- Requests from non-holders in `HOLD` are ignored; they are not queued beyond their level.
- Holder drop and hold expiry in the same cycle: the drop rule wins.

**Datapath**
- `r_Value` (7 bits) loads the granted requester's value every cycle while granted; it tracks live.
- Tens and units are derived from `r_Value` by /10 and %10.
- Each digit is decoded to 7 segments and registered. Segment order is {G,F,E,D,C,B,A}; outputs are inverted (active-low).
- `r_Value` > 99 displays "--": only G lit on both digits.
- While `IDLE`, both digits are blank (all outputs 1).

**Reset**
- `o_Grant` = 0, `o_Busy` = 0.
- All 14 segment outputs = 1 (blank).
- State = `IDLE`, hold counter = 0, `r_Last` = 2, so requester 0 wins first.
- Reset mid-grant drops the grant and blanks the display immediately (asynchronously).

**Widths**
- Hold counter is `$clog2(HOLD_CYCLES+1)` bits and never wraps; it saturates in `OPEN`.

## Timing
- `i_Req` sampled at edge k in `IDLE` → `o_Grant`/`o_Busy` valid after edge k.
- `r_Value` loads at edge k+1; segments show the value after edge k+2. Grant-to-display latency is 2 cycles.
- Value change at edge j while granted → segments update after edge j+2.
- Grant switch: the old grant is deasserted and the new one asserted on the same edge; `o_Grant` is never multi-hot.
- Minimum grant length with a competitor present is `HOLD_CYCLES` cycles, measured from the grant edge to the switch edge.
- Holder release at edge k → the new grant, or all-zero, appears after edge k. Segments blank after edge k+1 when going `IDLE`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use `HOLD_CYCLES=4`.

1. **Reset:** assert `i_Rst_L`=0 mid-grant → `o_Grant`=000 and all segments 1 without waiting for a clock edge; after release the first request from requester 0 is granted.
2. **Single requester:** `i_Req`=001, `i_Value_0`=42 → `o_Grant`=001 one cycle later. Two cycles later, tens segments {G..A} = ~1100110 and units = ~1011011. Display holds indefinitely in `OPEN`.
3. **Round-robin with hold:** `i_Req`=111 constant → grants 001, 010, 100, 001… each lasting exactly 4 cycles; never multi-hot.
4. **Early release:** requester 1 granted, drops its request after 2 cycles while requester 2 is requesting → `o_Grant`=100 on the next edge with no idle cycle. `o_Grant`=000 only when all requests are low.
5. **Boundaries:** value 0 → "00"; 99 → "99"; 100 and 127 → "--" (only G low on both digits). Live update from 9 to 10 appears 2 cycles later.
6. **Simultaneous events:** holder drops its request on the expiry cycle while another requester rises → the grant goes to that other requester; the hold counter restarts at 0.
